// File: rtl/pulsador_req.sv
// pulsador_req: debounced pedestrian push-button request with service handshake, timeout flag and request count.
// Define PULSADOR_DEBOUNCE_EN to compile in the DEB_CYCLES debounce filter; otherwise b_f is b_s delayed by one flop.
module pulsador_req #(
    parameter int DEB_CYCLES = 16,
    parameter int WAIT_MAX   = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       boton,
    input  logic       blanco,
    output logic       pulsador,
    output logic       espera,
    output logic       falla,
    output logic [7:0] req_count
);
    typedef enum logic [1:0] {IDLE, PEDIDO, SERVICIO} state_t;

    localparam logic [15:0] WAIT_LAST = 16'(WAIT_MAX - 1);
    localparam logic [15:0] WAIT_TOP  = 16'(WAIT_MAX);

    if (DEB_CYCLES < 2 || DEB_CYCLES > 255 || WAIT_MAX < 1 || WAIT_MAX > 65535) begin : g_bad_param
        $error("pulsador_req: DEB_CYCLES or WAIT_MAX out of range");
    end

    logic sync1_q, b_s_q, b_f_q, press;

`ifdef PULSADOR_DEBOUNCE_EN
    localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);
    logic [7:0] deb_q;
    logic       b_f_prev_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q    <= 1'b0;
            b_s_q      <= 1'b0;
            b_f_q      <= 1'b0;
            b_f_prev_q <= 1'b0;
            deb_q      <= 8'd0;
        end else begin
            sync1_q    <= boton;
            b_s_q      <= sync1_q;
            b_f_prev_q <= b_f_q;
            if (b_s_q == b_f_q) begin
                deb_q <= 8'd0;
            end else if (deb_q == DEB_LAST) begin
                b_f_q <= b_s_q;
                deb_q <= 8'd0;
            end else begin
                deb_q <= deb_q + 8'd1;
            end
        end
    end

    assign press = b_f_q & ~b_f_prev_q;
`else
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            b_s_q   <= 1'b0;
            b_f_q   <= 1'b0;
        end else begin
            sync1_q <= boton;
            b_s_q   <= sync1_q;
            b_f_q   <= b_s_q;
        end
    end

    // Rising edge of b_f flagged in the cycle it is being loaded, giving 3-edge latency
    assign press = b_s_q & ~b_f_q;
`endif

    state_t      state_q;
    logic        pulsador_q, falla_q;
    logic [7:0]  count_q, count_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;

    assign count_d    = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
    assign wait_cnt_d = (wait_cnt_q == WAIT_TOP) ? wait_cnt_q : wait_cnt_q + 16'd1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            pulsador_q <= 1'b0;
            falla_q    <= 1'b0;
            count_q    <= 8'd0;
            wait_cnt_q <= 16'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (blanco) begin
                        state_q <= SERVICIO;
                    end else if (press) begin
                        state_q    <= PEDIDO;
                        pulsador_q <= 1'b1;
                        count_q    <= count_d;
                        wait_cnt_q <= 16'd0;
                    end
                end
                PEDIDO: begin
                    if (blanco) begin
                        state_q    <= SERVICIO;
                        pulsador_q <= 1'b0;
                    end else begin
                        wait_cnt_q <= wait_cnt_d;
                        if (wait_cnt_q == WAIT_LAST) falla_q <= 1'b1;
                    end
                end
                SERVICIO: if (!blanco) state_q <= IDLE;
                default:  state_q <= IDLE;
            endcase
        end
    end

    assign pulsador  = pulsador_q;
    assign espera    = pulsador_q;
    assign falla     = falla_q;
    assign req_count = count_q;
endmodule
